mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Resolves branches and performs loads and stores on an external 32-bit data memory using a req/ready handshake.
- Stalls upstream stages while a memory access is outstanding.
- Registers results into MEM/WB outputs for the writeback stage.

Parameters:
ADDR_WIDTH, 32, width of mem_addr; the low ADDR_WIDTH bits of ALUresult_in are used.

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
valid_in  input  1  EX/MEM holds a real instruction (0 = bubble)
regWrite_in  input  1  instruction writes rd
memtoReg_in  input  1  instruction is a load
memWrite_in  input  1  instruction is a store
sb_in  input  1  store is byte-sized (else word)
lh_in  input  1  load is signed halfword (else word)
zeroFlag_in  input  1  ALU zero flag
branch_in  input  2  00 none, 01 beq, 10 bne, 11 none
readData2_in  input  32  store data
ALUresult_in  input  32  address or ALU result
rd_in  input  5  destination register
mem_req  output  1  access request, held until mem_ready
mem_we  output  1  1 = write
mem_addr  output  ADDR_WIDTH  word-aligned address, bits [1:0] = 0
mem_wdata  output  32  write data
mem_wstrb  output  4  byte enables
mem_rdata  input  32  read data, valid when mem_ready
mem_ready  input  1  access complete this cycle
stall  output  1  hold PC, IF/ID, ID/EX and EX/MEM
pcSrc  output  1  take branch
regWrite  output  1  MEM/WB regWrite
memtoReg  output  1  MEM/WB memtoReg
readData  output  32  MEM/WB load result
ALUresult  output  32  MEM/WB ALU result
rd  output  5  MEM/WB destination

Behaviour:
- Reset (asynchronous):
  - state = IDLE.
  - mem_req, mem_we, mem_wstrb, stall, regWrite, memtoReg, readData, ALUresult and rd are all 0.
  - An in-flight request is abandoned and mem_req drops immediately.
- Definitions:
  - access = valid_in & (memtoReg_in | memWrite_in).
  - start = (state == IDLE) & access.
- FSM:
  - IDLE:
    - On start, latch opcode fields, address and store data; go to WAIT.
    - Otherwise (non-access), update MEM/WB on the same edge. A bubble (valid_in = 0) loads regWrite = 0 and memtoReg = 0.
  - WAIT:
    - mem_req = 1. mem_addr, mem_we, mem_wdata and mem_wstrb are stable from the latched values.
    - On mem_ready: update MEM/WB, then return to IDLE.
- stall = start | (state == WAIT & ~mem_ready). It is combinational.
  - Upstream advances on the edge where mem_ready is seen.
  - Minimum access latency is 2 cycles.
  - Zero-wait memory (mem_ready = 1 in the first WAIT cycle) gives 1 stall cycle.
- Store behaviour:
  - mem_addr = {addr[ADDR_WIDTH-1:2], 2'b00}.
  - Word store: wstrb = 4'hF, wdata = readData2.
  - Byte store (sb): wstrb = 4'b0001 << addr[1:0], wdata = {4{readData2[7:0]}}.
- Load behaviour:
  - mem_we = 0, wstrb = 0.
  - Word load: readData = mem_rdata.
  - lh: half = addr[1] ? rdata[31:16] : rdata[15:0]; readData = sign-extended half.
  - mem_rdata is sampled only on the mem_ready cycle.
- On completion:
  - Stores load regWrite into MEM/WB as the latched regWrite_in value. This value is 0 for correct decode.
  - For a store, readData holds its previous value.
- pcSrc is combinational: valid_in & ((branch==01 & zeroFlag_in) | (branch==10 & ~zeroFlag_in)). It is independent of FSM state.
- mem_ready while in IDLE is ignored.
- memWrite_in and memtoReg_in both set: treated as a store.

Optional Feature:
MEM_MISALIGN_TRAP_EN
- Defined:
  - Adds output misalign (1 bit, reset 0).
  - A word access with addr[1:0] != 0, or an lh with addr[0] = 1, issues no request and does not stall.
  - It completes in IDLE like a non-access, with regWrite = 0 and misalign = 1 for that MEM/WB cycle.
  - misalign is 0 otherwise.
- Undefined: addr[1:0] is ignored for word accesses and addr[0] is ignored for lh. The port is absent.

Test Plan:
- Word store: ALUresult = 0x104, readData2 = 0xDEADBEEF, memWrite = 1, mem_ready after 3 WAIT cycles. Required: mem_addr = 0x104, wstrb = F, we = 1, stall high for 3 cycles then low on the ready cycle.
- Byte store: addr = 0x203, data = 0x000000A5, sb = 1. Required: wstrb = 1000, wdata = 0xA5A5A5A5, mem_addr = 0x200.
- lh: addr = 0x302, mem_rdata = 0x8001_1234, zero-wait memory. Required: readData = 0xFFFF8001, regWrite = 1, 1 stall cycle.
- ALU op: ALUresult = 0x55, rd = 7, regWrite = 1, then a bubble. Required: MEM/WB shows 0x55/7/1 after 1 edge, then regWrite = 0; no mem_req.
- beq with zero = 1 gives pcSrc = 1; bne with zero = 1 gives pcSrc = 0; valid_in = 0 gives pcSrc = 0.
- Assert reset during WAIT. Required: mem_req, stall and regWrite drop to 0 asynchronously; after release, state = IDLE and a late mem_ready is ignored.

Source files
------------

// File: rtl/mem_access_stage.sv
// Purpose: MEM stage - resolves branches, runs loads/stores on a req/ready data memory, registers MEM/WB.
// Latency: non-access instructions reach MEM/WB in 1 edge; memory accesses take >= 2 cycles (1 + wait states).
// Backpressure: stall holds upstream from the start cycle until mem_ready; optional MEM_MISALIGN_TRAP_EN adds a misalign trap output.
module mem_access_stage #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic                  regWrite_in,
  input  logic                  memtoReg_in,
  input  logic                  memWrite_in,
  input  logic                  sb_in,
  input  logic                  lh_in,
  input  logic                  zeroFlag_in,
  input  logic [1:0]            branch_in,
  input  logic [31:0]           readData2_in,
  input  logic [31:0]           ALUresult_in,
  input  logic [4:0]            rd_in,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  output logic                  stall,
  output logic                  pcSrc,
  output logic                  regWrite,
  output logic                  memtoReg,
  output logic [31:0]           readData,
  output logic [31:0]           ALUresult,
  output logic [4:0]            rd
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic                  misalign
`endif
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // Fields captured at access start; held stable for the whole WAIT phase
  logic        r_we;
  logic        r_sb;
  logic        r_lh;
  logic        r_rw;
  logic        r_m2r;
  logic [31:0] r_alu;
  logic [31:0] r_wd;
  logic [4:0]  r_rd;

  logic        w_access;
  logic        w_start;
  logic        w_misalign;
  logic [15:0] w_half;
  logic [31:0] w_load;

  assign w_access = valid_in & (memtoReg_in | memWrite_in);

`ifdef MEM_MISALIGN_TRAP_EN
  logic w_word;
  // A store's size comes from sb, a load's from lh (store wins when both flags set)
  assign w_word     = memWrite_in ? ~sb_in : ~lh_in;
  assign w_misalign = w_access & ((w_word & (ALUresult_in[1:0] != 2'b00)) |
                                  (~memWrite_in & lh_in & ALUresult_in[0]));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_start = (r_state == S_IDLE) & w_access & ~w_misalign;

  // Gated by reset so the stall drops asynchronously even if EX/MEM still holds an access
  assign stall = ~reset & (w_start | ((r_state == S_WAIT) & ~mem_ready));

  assign pcSrc = valid_in & (((branch_in == 2'b01) & zeroFlag_in) |
                             ((branch_in == 2'b10) & ~zeroFlag_in));

  assign mem_req   = (r_state == S_WAIT);
  assign mem_we    = mem_req & r_we;
  assign mem_addr  = {r_alu[ADDR_WIDTH-1:2], 2'b00};
  assign mem_wdata = r_sb ? {4{r_wd[7:0]}} : r_wd;
  assign mem_wstrb = !mem_we ? 4'h0 : (r_sb ? (4'b0001 << r_alu[1:0]) : 4'hF);

  assign w_half = r_alu[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  assign w_load = r_lh ? {{16{w_half[15]}}, w_half} : mem_rdata;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state: IDLE -> WAIT on start, WAIT -> IDLE on mem_ready
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start)   w_state_nxt = S_WAIT;
      S_WAIT:  if (mem_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Capture the access fields on the start edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we  <= 1'b0;
      r_sb  <= 1'b0;
      r_lh  <= 1'b0;
      r_rw  <= 1'b0;
      r_m2r <= 1'b0;
      r_alu <= 32'h0;
      r_wd  <= 32'h0;
      r_rd  <= 5'h0;
    end else if (w_start) begin
      r_we  <= memWrite_in;
      r_sb  <= memWrite_in & sb_in;
      r_lh  <= ~memWrite_in & lh_in;
      r_rw  <= regWrite_in;
      r_m2r <= memtoReg_in & ~memWrite_in;
      r_alu <= ALUresult_in;
      r_wd  <= readData2_in;
      r_rd  <= rd_in;
    end
  end

  // MEM/WB register: non-access instructions pass in IDLE, accesses land on the mem_ready edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regWrite  <= 1'b0;
      memtoReg  <= 1'b0;
      readData  <= 32'h0;
      ALUresult <= 32'h0;
      rd        <= 5'h0;
    end else if (r_state == S_IDLE) begin
      if (!w_start) begin
        regWrite  <= valid_in & regWrite_in & ~w_misalign;
        memtoReg  <= valid_in & memtoReg_in;
        ALUresult <= ALUresult_in;
        rd        <= rd_in;
      end
    end else if (mem_ready) begin
      regWrite  <= r_rw;
      memtoReg  <= r_m2r;
      ALUresult <= r_alu;
      rd        <= r_rd;
      if (!r_we) readData <= w_load;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // Trap flag accompanies the MEM/WB slot of the trapped instruction only
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     misalign <= 1'b0;
    else if (r_state == S_IDLE)    misalign <= w_misalign;
    else if (mem_ready)            misalign <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a request/MEM-WB scoreboard.
// Expected request and writeback values are pushed when an access is driven.
// They are popped and compared when the DUT issues the request / completes.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in, regWrite_in, memtoReg_in, memWrite_in, sb_in, lh_in, zeroFlag_in;
  logic [1:0]  branch_in;
  logic [31:0] readData2_in, ALUresult_in;
  logic [4:0]  rd_in;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall, pcSrc, regWrite, memtoReg;
  logic [31:0] readData, ALUresult;
  logic [4:0]  rd;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .regWrite_in(regWrite_in),
    .memtoReg_in(memtoReg_in), .memWrite_in(memWrite_in), .sb_in(sb_in), .lh_in(lh_in),
    .zeroFlag_in(zeroFlag_in), .branch_in(branch_in), .readData2_in(readData2_in),
    .ALUresult_in(ALUresult_in), .rd_in(rd_in), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall), .pcSrc(pcSrc),
    .regWrite(regWrite), .memtoReg(memtoReg), .readData(readData),
    .ALUresult(ALUresult), .rd(rd)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        chk_wdata;
  } req_t;

  typedef struct {
    logic        rw;
    logic        m2r;
    logic        chk_m2r;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  rd;
  } wb_t;

  req_t        req_q[$];
  wb_t         wb_q[$];
  logic [31:0] last_rdata = 32'h0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_instr(input logic v, input logic rw, input logic m2r, input logic mw,
                           input logic sbb, input logic lhh, input logic [1:0] br,
                           input logic z, input logic [31:0] d2, input logic [31:0] alu,
                           input logic [4:0] r);
    valid_in = v; regWrite_in = rw; memtoReg_in = m2r; memWrite_in = mw;
    sb_in = sbb; lh_in = lhh; branch_in = br; zeroFlag_in = z;
    readData2_in = d2; ALUresult_in = alu; rd_in = r;
  endtask

  // Drive one memory instruction, model it, and run the handshake with nwait WAIT cycles
  task automatic issue(input string tag, input logic rw, input logic m2r, input logic mw,
                       input logic sbb, input logic lhh, input logic [31:0] d2,
                       input logic [31:0] alu, input logic [4:0] r, input int nwait,
                       input logic [31:0] rdata);
    req_t        e;
    wb_t         w;
    logic [15:0] h;
    int          stalls;
    int          reqs;
    set_instr(1'b1, rw, m2r, mw, sbb, lhh, 2'b00, 1'b0, d2, alu, r);
    e.addr      = {alu[31:2], 2'b00};
    e.we        = mw;
    e.wstrb     = mw ? (sbb ? (4'b0001 << alu[1:0]) : 4'hF) : 4'h0;
    e.wdata     = sbb ? {4{d2[7:0]}} : d2;
    e.chk_wdata = mw;
    if (!mw) begin
      h = alu[1] ? rdata[31:16] : rdata[15:0];
      last_rdata = lhh ? {{16{h[15]}}, h} : rdata;
    end
    w.rw = rw; w.m2r = m2r; w.chk_m2r = ~(mw & m2r);
    w.rdata = last_rdata; w.alu = alu; w.rd = r;
    req_q.push_back(e);
    wb_q.push_back(w);

    stalls = 0;
    reqs = 0;
    #1;
    if (stall) stalls++;
    chk({tag, ".req_idle"}, mem_req, 1'b0);
    @(posedge clk); #1;
    e = req_q.pop_front();
    chk({tag, ".addr"}, mem_addr, e.addr);
    chk({tag, ".we"}, mem_we, e.we);
    chk({tag, ".wstrb"}, mem_wstrb, e.wstrb);
    if (e.chk_wdata) chk({tag, ".wdata"}, mem_wdata, e.wdata);
    for (int k = 1; k <= nwait; k++) begin
      if (mem_req) reqs++;
      if (k == nwait) begin
        mem_ready = 1'b1;
        mem_rdata = rdata;
      end
      #1;
      if (stall) stalls++;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    chk({tag, ".stall_cycles"}, stalls, nwait);
    chk({tag, ".req_cycles"}, reqs, nwait);
    chk({tag, ".req_done"}, mem_req, 1'b0);
    w = wb_q.pop_front();
    chk({tag, ".wb_regWrite"}, regWrite, w.rw);
    if (w.chk_m2r) chk({tag, ".wb_memtoReg"}, memtoReg, w.m2r);
    chk({tag, ".wb_readData"}, readData, w.rdata);
    chk({tag, ".wb_ALUresult"}, ALUresult, w.alu);
    chk({tag, ".wb_rd"}, rd, w.rd);
    valid_in = 1'b0;
  endtask

  logic       pc_v[6]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [1:0] pc_br[6]  = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b11};
  logic       pc_z[6]   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic       pc_exp[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    set_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0);
    #2;
    chk("rst.mem_req", mem_req, 1'b0);
    chk("rst.mem_we", mem_we, 1'b0);
    chk("rst.mem_wstrb", mem_wstrb, 4'h0);
    chk("rst.stall", stall, 1'b0);
    chk("rst.regWrite", regWrite, 1'b0);
    chk("rst.memtoReg", memtoReg, 1'b0);
    chk("rst.readData", readData, 32'h0);
    chk("rst.ALUresult", ALUresult, 32'h0);
    chk("rst.rd", rd, 5'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Stores, loads and a store with both memtoReg and memWrite set
    issue("wst",   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 32'h104, 5'd3,  3, 32'h0);
    issue("bst3",  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h000000A5, 32'h203, 5'd4,  2, 32'h0);
    issue("bst1",  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1234563C, 32'h201, 5'd5,  1, 32'h0);
    issue("lh_hi", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,        32'h302, 5'd9,  1, 32'h80011234);
    issue("lh_lo", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,        32'h300, 5'd10, 2, 32'h80007FFE);
    issue("lw",    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h400, 5'd11, 2, 32'h12345678);
    issue("both",  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hCAFEF00D, 32'h500, 5'd12, 1, 32'h0);

    // ALU op then bubble
    set_instr(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h55, 5'd7);
    #1;
    chk("alu.stall", stall, 1'b0);
    chk("alu.mem_req", mem_req, 1'b0);
    @(posedge clk); #1;
    chk("alu.regWrite", regWrite, 1'b1);
    chk("alu.ALUresult", ALUresult, 32'h55);
    chk("alu.rd", rd, 5'd7);
    chk("alu.readData_hold", readData, last_rdata);
    set_instr(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h66, 5'd8);
    @(posedge clk); #1;
    chk("bubble.regWrite", regWrite, 1'b0);
    chk("bubble.memtoReg", memtoReg, 1'b0);
    chk("bubble.mem_req", mem_req, 1'b0);
    chk("bubble.stall", stall, 1'b0);

    // Branch resolution
    for (int i = 0; i < 6; i++) begin
      set_instr(pc_v[i], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pc_br[i], pc_z[i], 32'h0, 32'h0, 5'd0);
      #1;
      chk($sformatf("pcsrc.%0d", i), pcSrc, pc_exp[i]);
    end

    // Reset during WAIT, then a late mem_ready
    set_instr(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h77, 5'd6);
    @(posedge clk); #1;
    chk("pre.regWrite", regWrite, 1'b1);
    set_instr(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h600, 5'd13);
    @(posedge clk); #1;
    chk("wait.mem_req", mem_req, 1'b1);
    chk("wait.stall", stall, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst.mem_req", mem_req, 1'b0);
    chk("arst.stall", stall, 1'b0);
    chk("arst.regWrite", regWrite, 1'b0);
    chk("arst.rd", rd, 5'd0);
    @(negedge clk);
    reset = 1'b0;
    valid_in = 1'b0;
    ALUresult_in = 32'h0;
    rd_in = 5'd0;
    mem_ready = 1'b1;
    mem_rdata = 32'hDEADDEAD;
    #1;
    chk("late.stall", stall, 1'b0);
    chk("late.mem_req", mem_req, 1'b0);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    chk("late.readData", readData, 32'h0);
    chk("late.regWrite", regWrite, 1'b0);
    chk("late.mem_req_after", mem_req, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
